// File: rtl/result_display_driver_pkg.sv
// Shared constants for the result display: segment patterns, FSM state codes
// and the 5-bit digit code ({blank, value}) consumed by seg7_decoder.
package result_display_driver_pkg;

  localparam int unsigned Y_W     = 8;
  localparam int unsigned DIGIT_W = 5;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] CONVERT = 1'b1;

  typedef logic [DIGIT_W-1:0] digit_code_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

  localparam digit_code_t DIGIT_BLANK = 5'b1_0000;

  function automatic digit_code_t digit_code(input logic [3:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/result_display_driver_if.sv
// Bus between the mux stage / board pins and result_display_driver.
interface result_display_driver_if;
  import result_display_driver_pkg::*;

  logic [Y_W-1:0] Y;
  logic           load;
  logic           hex;
  logic           busy;
  logic [3:0]     an;
  logic [6:0]     seg;
  logic           dp;

  modport master (output Y, load, hex, input busy, an, seg, dp);
  modport slave  (input Y, load, hex, output busy, an, seg, dp);

endinterface

// File: rtl/result_display_driver_seg7_decoder.sv
// Combinational 7-segment decoder: 5-bit digit code in, active-low pattern out.
module seg7_decoder
  import result_display_driver_pkg::*;
(
  input  digit_code_t code_i,
  output logic [6:0]  seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!code_i[DIGIT_W-1]) seg_o = SEG_HEX[code_i[3:0]];
  end

endmodule

// File: rtl/result_display_driver.sv
// Latches Y, converts it to BCD with a serial double-dabble (or passes nibbles
// in hex mode) and scans the result onto a 4-digit common-anode display.
module result_display_driver
  import result_display_driver_pkg::*;
#(
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter int unsigned STEPS       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  result_display_driver_if.slave  bus
);

  logic [0:0]     state_q, state_d;
  logic [Y_W-1:0] bin_q, bin_d;
  logic [11:0]    bcd_q, bcd_d, adj;
  logic [19:0]    shifted;
  logic [3:0]     step_q, step_d;
  logic           hexc_q, hexc_d;
  logic           busy_q, busy_d;
  logic [3:0]     ones_q, ones_d, tens_q, tens_d, hund_q, hund_d;
  logic           dhex_q, dhex_d;
  logic [15:0]    pre_q, pre_d;
  logic [1:0]     idx_q, idx_d;
  logic [3:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  digit_code_t [3:0] codes;
  digit_code_t    sel_code;

  // Hex mode skips add-3, so after STEPS shifts the accumulator holds {0, Y}.
  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (!hexc_q && adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    shifted = {adj, bin_q} << 1;

    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    hexc_d  = hexc_q;
    busy_d  = busy_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    dhex_d  = dhex_q;

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          bin_d   = bus.Y;
          hexc_d  = bus.hex;
          bcd_d   = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      default: begin
        {bcd_d, bin_d} = shifted;
        step_d = step_q + 4'd1;
        if (step_q == 4'(STEPS - 1)) begin
          ones_d  = bcd_d[3:0];
          tens_d  = bcd_d[7:4];
          hund_d  = bcd_d[11:8];
          dhex_d  = hexc_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  // Built from next-state digits so a completed value appears on the commit edge.
  always_comb begin
    codes[0] = digit_code(ones_d);
    codes[3] = DIGIT_BLANK;
    if (dhex_d) begin
      codes[1] = digit_code(tens_d);
      codes[2] = DIGIT_BLANK;
    end else begin
      codes[1] = (hund_d == 4'd0 && tens_d == 4'd0) ? DIGIT_BLANK : digit_code(tens_d);
      codes[2] = (hund_d == 4'd0) ? DIGIT_BLANK : digit_code(hund_d);
    end

    pre_d = pre_q + 16'd1;
    idx_d = idx_q;
    if (pre_q == REFRESH_DIV - 16'd1) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
    an_d     = ~(4'b0001 << idx_d);
    sel_code = codes[idx_d];
  end

  seg7_decoder u_dec (
    .code_i (sel_code),
    .seg_o  (seg_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      hexc_q  <= 1'b0;
      busy_q  <= 1'b0;
      ones_q  <= '0;
      tens_q  <= '0;
      hund_q  <= '0;
      dhex_q  <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= '1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      hexc_q  <= hexc_d;
      busy_q  <= busy_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
      dhex_q  <= dhex_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = 1'b1;

endmodule

// File: tb/tb_result_display_driver.sv
// Self-checking bench for result_display_driver with a fast refresh divider.
module tb_result_display_driver;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_display_driver_if bus ();

  result_display_driver #(.REFRESH_DIV(16'(DIV)), .STEPS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int errors = 0;
  int checks = 0;

  int n;
  int disp_val;
  bit disp_hex;
  int pend_val;
  bit pend_hex;
  bit busy_m;
  int cnt;

  function automatic logic [6:0] exp_seg(int idx, int val, bit hx);
    int h, t, o;
    if (hx) begin
      if (idx == 0) return segtab[val % 16];
      if (idx == 1) return segtab[val / 16];
      return 7'h7F;
    end
    h = val / 100;
    t = (val / 10) % 10;
    o = val % 10;
    case (idx)
      0: return segtab[o];
      1: return (h == 0 && t == 0) ? 7'h7F : segtab[t];
      2: return (h == 0) ? 7'h7F : segtab[h];
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_an"},   32'(bus.an),   32'hF);
    check({tag, "_seg"},  32'(bus.seg),  32'h7F);
    check({tag, "_dp"},   32'(bus.dp),   32'd1);
  endtask

  task automatic model_reset();
    n = 0; disp_val = 0; disp_hex = 0; busy_m = 0; cnt = 0;
    pend_val = 0; pend_hex = 0;
  endtask

  task automatic check_outputs();
    int idx;
    logic [3:0] ea;
    idx = (n / DIV) % 4;
    ea = 4'hF;
    ea[idx] = 1'b0;
    check("busy", 32'(bus.busy), 32'(busy_m));
    check("an",   32'(bus.an),   32'(ea));
    check("seg",  32'(bus.seg),  32'(exp_seg(idx, disp_val, disp_hex)));
    check("dp",   32'(bus.dp),   32'd1);
  endtask

  // Called at a falling edge: drive inputs, advance one rising edge, check.
  task automatic cycle(bit ld, logic [7:0] y, bit hx);
    bus.load = ld;
    bus.Y    = y;
    bus.hex  = hx;
    @(posedge clk);
    n++;
    if (busy_m) begin
      cnt++;
      if (cnt == 8) begin
        disp_val = pend_val;
        disp_hex = pend_hex;
        busy_m   = 0;
      end
    end else if (ld) begin
      pend_val = int'(y);
      pend_hex = hx;
      busy_m   = 1;
      cnt      = 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 8'($urandom), 1'($urandom));
  endtask

  task automatic mid_reset();
    bus.load = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("held_rst");
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.load = 1'b0;
    bus.Y    = '0;
    bus.hex  = 1'b0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    model_reset();

    idle(20);

    cycle(1'b1, 8'd200, 1'b0); idle(20);
    cycle(1'b1, 8'd9,   1'b0); idle(20);
    cycle(1'b1, 8'hAF,  1'b1); idle(20);
    cycle(1'b1, 8'd100, 1'b0); idle(16);
    cycle(1'b1, 8'd0,   1'b0); idle(16);
    cycle(1'b1, 8'd255, 1'b0); idle(16);
    cycle(1'b1, 8'd10,  1'b0); idle(16);
    cycle(1'b1, 8'h0B,  1'b1); idle(16);

    cycle(1'b1, 8'd200, 1'b0);
    cycle(1'b0, 8'd0, 1'b0);
    cycle(1'b0, 8'd0, 1'b0);
    cycle(1'b1, 8'd55, 1'b0);
    idle(20);

    cycle(1'b1, 8'd123, 1'b0);
    idle(3);
    mid_reset();
    idle(20);

    for (int i = 0; i < 30; i++) cycle(1'b1, 8'($urandom), 1'($urandom));
    idle(16);

    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'($urandom), 1'($urandom));
      for (int j = 0; j < int'($urandom_range(0, 18)); j++)
        cycle(($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 19) == 0) mid_reset();
    end
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
